// File: rtl/invader_formation_mover.sv
// invader_formation_mover
// Moves the whole invader formation in fixed point. It marches the formation
// horizontally. On an edge hit it descends a fixed distance and then reverses
// direction. Speed rises in saturating levels, and the formation stops for good
// once it reaches the bottom row.
//
// Optional feature macro: INVADER_MOVE_BOUNDS_EN
//   When defined, the block also checks the X limits itself. A march that reaches
//   RIGHT_LIMIT or LEFT_LIMIT clamps X to that limit and raises a pending hit,
//   exactly as an external hit would.
//
// Ports:
//   clk, resetN       clock, asynchronous active-low reset
//   startOfFrame      one-cycle pulse per frame; all motion happens on this cycle
//   enable            1 = motion allowed; 0 = freeze position/state/pending hit
//   speedUp           one-cycle pulse: level +1, saturating at MAX_LEVEL
//   hitLeft/hitRight  edge contact reported by the collision logic
//   topLeftX/Y        formation corner in pixels (integer part, clamped at 0)
//   dirLeft           1 = marching left
//   descending        1 while descending
//   atBottom          sticky: formation reached BOTTOM_Y
//   level             current speed level
module invader_formation_mover #(
  parameter int FRAC_BITS   = 6,
  parameter int INIT_X      = 40,
  parameter int INIT_Y      = 60,
  parameter int BASE_SPEED  = 32,
  parameter int SPEED_STEP  = 16,
  parameter int MAX_LEVEL   = 7,
  parameter int DROP_PIX    = 16,
  parameter int DROP_SPEED  = 128,
  parameter int BOTTOM_Y    = 400
`ifdef INVADER_MOVE_BOUNDS_EN
  ,
  parameter int LEFT_LIMIT  = 0,
  parameter int RIGHT_LIMIT = 560
`endif
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        enable,
  input  logic        speedUp,
  input  logic        hitLeft,
  input  logic        hitRight,
  output logic [10:0] topLeftX,
  output logic [10:0] topLeftY,
  output logic        dirLeft,
  output logic        descending,
  output logic        atBottom,
  output logic [2:0]  level
);

  localparam int unsigned PW         = 11 + FRAC_BITS + 1;
  localparam int unsigned DROP_TOTAL = DROP_PIX << FRAC_BITS;
  localparam int unsigned DW         = $clog2(DROP_TOTAL + 1);

`ifdef INVADER_MOVE_BOUNDS_EN
  localparam int unsigned LEFT_POS   = LEFT_LIMIT << FRAC_BITS;
  localparam int unsigned RIGHT_POS  = RIGHT_LIMIT << FRAC_BITS;
`endif

  typedef enum logic [1:0] {MARCH_R, MARCH_L, DESCEND, STOPPED} state_t;

  state_t               state, state_n;
  logic signed [PW-1:0] pos_x, pos_y, pos_x_n, pos_y_n;
  logic [DW-1:0]        drop_cnt, drop_n, drop_rem, drop_step;
  logic [PW-1:0]        speed;
  logic                 pend_hit, pend_n;
  logic                 ret_left, ret_n;
  logic                 dir_n, bottom_n, hit_c, move;
  logic [2:0]           level_n;
`ifdef INVADER_MOVE_BOUNDS_EN
  logic [10:0]          new_px;
`endif

  // Integer pixel part of a fixed-point position; negative positions read as 0.
  function automatic logic [10:0] to_pix(input logic signed [PW-1:0] p);
    return p[PW-1] ? 11'd0 : 11'(p >>> FRAC_BITS);
  endfunction

  // Next-state and datapath computation.
  always_comb begin
    state_n  = state;
    pos_x_n  = pos_x;
    pos_y_n  = pos_y;
    pend_n   = pend_hit;
    drop_n   = drop_cnt;
    ret_n    = ret_left;
    dir_n    = dirLeft;
    bottom_n = atBottom;
    hit_c    = 1'b0;
`ifdef INVADER_MOVE_BOUNDS_EN
    new_px   = 11'd0;
`endif
    move      = startOfFrame & enable;
    // The move on a speedUp frame still uses the level held in the register.
    speed     = PW'(BASE_SPEED) + PW'(level) * PW'(SPEED_STEP);
    drop_rem  = DW'(DROP_TOTAL) - drop_cnt;
    drop_step = (drop_rem > DW'(DROP_SPEED)) ? DW'(DROP_SPEED) : drop_rem;
    level_n   = (speedUp && level != 3'(MAX_LEVEL)) ? 3'(level + 3'd1) : level;

    case (state)
      MARCH_R, MARCH_L: begin
        hit_c = (state == MARCH_R) ? hitRight : hitLeft;
        if (move && pend_hit) begin
          // The frame that starts a descent makes no X move.
          state_n = DESCEND;
          pend_n  = 1'b0;
          drop_n  = '0;
          ret_n   = (state == MARCH_R);
        end else begin
          pend_n = pend_hit | hit_c;
          if (move) begin
            if (state == MARCH_R) pos_x_n = pos_x + $signed(speed);
            else                  pos_x_n = pos_x - $signed(speed);
`ifdef INVADER_MOVE_BOUNDS_EN
            new_px = to_pix(pos_x_n);
            if (state == MARCH_R && new_px >= 11'(RIGHT_LIMIT)) begin
              pos_x_n = PW'(RIGHT_POS);
              pend_n  = 1'b1;
            end else if (state == MARCH_L && new_px <= 11'(LEFT_LIMIT)) begin
              pos_x_n = PW'(LEFT_POS);
              pend_n  = 1'b1;
            end
`endif
          end
        end
      end
      DESCEND: begin
        if (move) begin
          // The last step is shortened so the total descent is exactly DROP_PIX.
          pos_y_n = pos_y + $signed(PW'(drop_step));
          drop_n  = drop_cnt + drop_step;
          if (drop_n == DW'(DROP_TOTAL)) begin
            state_n = ret_left ? MARCH_L : MARCH_R;
            dir_n   = ret_left;
          end
        end
      end
      default: ;
    endcase

    // Reaching the bottom overrides any other state change.
    if (move && state != STOPPED && to_pix(pos_y_n) >= 11'(BOTTOM_Y)) begin
      bottom_n = 1'b1;
      state_n  = STOPPED;
    end
  end

  // State, position and registered outputs.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= MARCH_R;
      pos_x      <= PW'(INIT_X << FRAC_BITS);
      pos_y      <= PW'(INIT_Y << FRAC_BITS);
      drop_cnt   <= '0;
      pend_hit   <= 1'b0;
      ret_left   <= 1'b0;
      level      <= 3'd0;
      topLeftX   <= 11'(INIT_X);
      topLeftY   <= 11'(INIT_Y);
      dirLeft    <= 1'b0;
      descending <= 1'b0;
      atBottom   <= 1'b0;
    end else begin
      state      <= state_n;
      pos_x      <= pos_x_n;
      pos_y      <= pos_y_n;
      drop_cnt   <= drop_n;
      pend_hit   <= pend_n;
      ret_left   <= ret_n;
      level      <= level_n;
      topLeftX   <= to_pix(pos_x_n);
      topLeftY   <= to_pix(pos_y_n);
      dirLeft    <= dir_n;
      descending <= (state_n == DESCEND);
      atBottom   <= bottom_n;
    end
  end

endmodule

// File: tb/tb_invader_formation_mover.sv
// Self-checking bench for invader_formation_mover: directed scenarios plus
// randomized traffic, compared every cycle against a behavioural model.
module tb_invader_formation_mover;

  localparam int F          = 6;
  localparam int BASE       = 32;
  localparam int STEP       = 16;
  localparam int MAXL       = 7;
  localparam int DROP_TOTAL = 16 << F;
  localparam int DSPEED     = 128;
  localparam int BOT        = 400;
`ifdef INVADER_MOVE_BOUNDS_EN
  localparam int LEFT       = 0;
  localparam int RIGHT      = 560;
`endif

  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic startOfFrame = 1'b0, enable = 1'b0, speedUp = 1'b0;
  logic hitLeft = 1'b0, hitRight = 1'b0;
  logic [10:0] topLeftX, topLeftY;
  logic dirLeft, descending, atBottom;
  logic [2:0] level;

  invader_formation_mover dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .enable(enable),
    .speedUp(speedUp), .hitLeft(hitLeft), .hitRight(hitRight),
    .topLeftX(topLeftX), .topLeftY(topLeftY), .dirLeft(dirLeft),
    .descending(descending), .atBottom(atBottom), .level(level)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Behavioural model: sub-pixel integers, direction as +1/-1, and the
  // distance still to descend.
  int mx, my, mdir, mremain, mlevel;
  bit mdesc, mstop, mpend, mbottom;

  function automatic int pix(input int v);
    return (v < 0) ? 0 : ((v >>> F) & 2047);
  endfunction

  task automatic model_reset();
    mx = 40 << F; my = 60 << F; mdir = 1; mremain = 0; mlevel = 0;
    mdesc = 0; mstop = 0; mpend = 0; mbottom = 0;
  endtask

  task automatic model_step(input bit sof, input bit en, input bit su,
                            input bit hl, input bit hr);
    int spd, d;
    bit go, hit;
    spd = BASE + mlevel * STEP;
    if (su && mlevel < MAXL) mlevel++;
    if (mstop) return;
    go = sof && en;
    if (mdesc) begin
      if (go) begin
        d = (mremain < DSPEED) ? mremain : DSPEED;
        my += d;
        mremain -= d;
        if (mremain == 0) begin
          mdesc = 0;
          mdir = -mdir;
        end
      end
    end else begin
      hit = (mdir > 0) ? hr : hl;
      if (go && mpend) begin
        mdesc = 1; mremain = DROP_TOTAL; mpend = 0;
      end else begin
        if (hit) mpend = 1;
        if (go) begin
          mx += mdir * spd;
`ifdef INVADER_MOVE_BOUNDS_EN
          if (mdir > 0 && pix(mx) >= RIGHT) begin mx = RIGHT << F; mpend = 1; end
          else if (mdir < 0 && pix(mx) <= LEFT) begin mx = LEFT << F; mpend = 1; end
`endif
        end
      end
    end
    if (go && pix(my) >= BOT) begin
      mbottom = 1; mstop = 1;
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".x"},    int'(topLeftX),   pix(mx));
    chk({tag, ".y"},    int'(topLeftY),   pix(my));
    chk({tag, ".dirl"}, int'(dirLeft),    (mdir < 0) ? 1 : 0);
    chk({tag, ".desc"}, int'(descending), (mdesc && !mstop) ? 1 : 0);
    chk({tag, ".bot"},  int'(atBottom),   int'(mbottom));
    chk({tag, ".lvl"},  int'(level),      mlevel);
  endtask

  task automatic step(input bit sof, input bit en, input bit su,
                      input bit hl, input bit hr, input string tag);
    @(negedge clk);
    startOfFrame = sof; enable = en; speedUp = su; hitLeft = hl; hitRight = hr;
    @(posedge clk);
    model_step(sof, en, su, hl, hr);
    #1 compare_all(tag);
  endtask

  task automatic frame(input bit en, input string tag);
    step(1'b1, en, 1'b0, 1'b0, 1'b0, tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    resetN = 1'b0;
    startOfFrame = 0; enable = 0; speedUp = 0; hitLeft = 0; hitRight = 0;
    model_reset();
    #1 compare_all(tag);
    @(negedge clk);
    resetN = 1'b1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sx, sy, iter;
    bit s_sof, s_en, s_su, s_hl, s_hr;

    do_reset("rst");
    chk("rst.x_const", int'(topLeftX), 40);
    chk("rst.y_const", int'(topLeftY), 60);

    // Level-0 march: 4 frames x 32 sub-pixels = 2 pixels.
    for (int i = 0; i < 4; i++) frame(1'b1, "march0");
    chk("march0.x_const", int'(topLeftX), 42);

    // Right-edge hit: the entry frame makes no X move, then 8 descent frames.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "hitr");
    frame(1'b1, "desc_entry");
    chk("desc_entry.desc", int'(descending), 1);
    chk("desc_entry.x_const", int'(topLeftX), 42);
    for (int i = 0; i < 8; i++) frame(1'b1, "desc");
    chk("desc.y_const", int'(topLeftY), 76);
    chk("desc.dirl_const", int'(dirLeft), 1);
    chk("desc.done", int'(descending), 0);

    // Nine speedUp pulses saturate at level 7, then march left at 144 per frame.
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "spd");
    chk("spd.lvl_const", int'(level), 7);
    for (int i = 0; i < 3; i++) frame(1'b1, "fast");
    chk("fast.x_const", int'(topLeftX), 35);

    // A hit while disabled is held, and the descent starts on the first enabled frame.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "hitl_dis");
    for (int i = 0; i < 3; i++) frame(1'b0, "frozen");
    chk("frozen.x_const", int'(topLeftX), 35);
    frame(1'b1, "resume");
    chk("resume.desc", int'(descending), 1);

    // Keep descending until the formation reaches the bottom.
    iter = 0;
    while (!mstop && iter < 3000) begin
      if (!mdesc) step(1'b0, 1'b1, 1'b0, mdir < 0, mdir > 0, "tobot_hit");
      frame(1'b1, "tobot");
      iter++;
    end
    chk("bottom.flag", int'(atBottom), 1);
    chk("bottom.y_min", (int'(topLeftY) >= BOT) ? 1 : 0, 1);
    sx = pix(mx); sy = pix(my);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, "stopped");
    chk("stopped.x_hold", int'(topLeftX), sx);
    chk("stopped.y_hold", int'(topLeftY), sy);

    // Reset in the middle of a descent; the next descent is still a full 16 pixels.
    do_reset("rst2");
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "hitr2");
    frame(1'b1, "desc2_entry");
    frame(1'b1, "desc2");
    do_reset("rst_mid");
    chk("rst_mid.x_const", int'(topLeftX), 40);
    chk("rst_mid.y_const", int'(topLeftY), 60);
    chk("rst_mid.desc", int'(descending), 0);
    chk("rst_mid.lvl", int'(level), 0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "hitr3");
    for (int i = 0; i < 9; i++) frame(1'b1, "desc3");
    chk("desc3.y_const", int'(topLeftY), 76);

    // Randomized traffic, including the hit-with-frame overlap and occasional resets.
    do_reset("rst_rand");
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 799) == 0) begin
        do_reset("rrst");
      end else begin
        s_sof = ($urandom_range(0, 3) == 0);
        s_en  = ($urandom_range(0, 9) != 0);
        s_su  = ($urandom_range(0, 39) == 0);
        s_hl  = ($urandom_range(0, 11) == 0);
        s_hr  = ($urandom_range(0, 11) == 0);
        step(s_sof, s_en, s_su, s_hl, s_hr, "rnd");
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
